// File: rtl/i2c_slave_bridge.sv
// Clock-domain bridge for the I2C slave: synchronises start/address-match, turns
// each addressed transaction into a valid/ready command frame, and stages read-back data.
module i2c_slave_bridge #(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        i2c_start,
   input  logic        i2c_addr_nm,
   input  logic [39:0] i2c_wr_data,
   output logic [39:0] i2c_rd_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [39:0] cmd_data,
   input  logic        rsp_load,
   input  logic [39:0] rsp_data,
   output logic        overrun,
   input  logic        overrun_clr,
   output logic [7:0]  txn_count,
   output logic        busy
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      ACTIVE,
      SETTLE,
      CAPTURE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] start_sync_q, nm_sync_q;
   logic                   start_s, nm_s;
   logic [CW-1:0]          settle_q, settle_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic [39:0]            cmd_data_q, cmd_data_d;
   logic                   overrun_q, overrun_d;
   logic [7:0]             txn_count_q, txn_count_d;
   logic [39:0]            rd_data_q, rd_data_d;
   logic [39:0]            pend_q, pend_d;
   logic                   pend_vld_q, pend_vld_d;
   logic                   capture_ok, capture_drop, apply_rsp;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         start_sync_q <= '1;
         nm_sync_q    <= '1;
      end else begin
         start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], i2c_start};
         nm_sync_q    <= {nm_sync_q[SYNC_STAGES-2:0], i2c_addr_nm};
      end
   end

   assign start_s = start_sync_q[SYNC_STAGES-1];
   assign nm_s    = nm_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= WAIT_IDLE;
         settle_q    <= '0;
         cmd_valid_q <= 1'b0;
         cmd_data_q  <= '0;
         overrun_q   <= 1'b0;
         txn_count_q <= '0;
         rd_data_q   <= '0;
         pend_q      <= '0;
         pend_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_data_q  <= cmd_data_d;
         overrun_q   <= overrun_d;
         txn_count_q <= txn_count_d;
         rd_data_q   <= rd_data_d;
         pend_q      <= pend_d;
         pend_vld_q  <= pend_vld_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      unique case (state_q)
         WAIT_IDLE: if (!start_s) state_d = IDLE;
         IDLE:      if (start_s) state_d = ACTIVE;
         ACTIVE: begin
            if (!start_s) begin
               state_d  = SETTLE;
               settle_d = CW'(SETTLE_CYCLES);
            end
         end
         SETTLE: begin
            // Leaving on the count of 1 makes the last settle cycle the one before CAPTURE.
            if (start_s) begin
               state_d = ACTIVE;
            end else begin
               settle_d = settle_q - CW'(1);
               if (settle_q == CW'(1)) state_d = CAPTURE;
            end
         end
         CAPTURE:   state_d = IDLE;
         default:   state_d = WAIT_IDLE;
      endcase
   end

   assign capture_ok   = (state_q == CAPTURE) && !nm_s && (!cmd_valid_q || cmd_ready);
   assign capture_drop = (state_q == CAPTURE) && !nm_s && cmd_valid_q && !cmd_ready;
   // Read-back data only moves while the synchronised bus is idle and no start is seen.
   assign apply_rsp    = pend_vld_q && !start_s && ((state_q == IDLE) || (state_q == WAIT_IDLE));

   always_comb begin
      cmd_valid_d = cmd_valid_q;
      cmd_data_d  = cmd_data_q;
      txn_count_d = txn_count_q;
      overrun_d   = overrun_q;
      if (capture_ok) begin
         cmd_valid_d = 1'b1;
         cmd_data_d  = i2c_wr_data;
         txn_count_d = txn_count_q + 8'd1;
      end else if (cmd_valid_q && cmd_ready) begin
         cmd_valid_d = 1'b0;
      end
      if (capture_drop)     overrun_d = 1'b1;
      else if (overrun_clr) overrun_d = 1'b0;
   end

   always_comb begin
      rd_data_d  = rd_data_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (apply_rsp) begin
         rd_data_d  = pend_q;
         pend_vld_d = 1'b0;
      end
      if (rsp_load) begin
         pend_d     = rsp_data;
         pend_vld_d = 1'b1;
      end
   end

   assign i2c_rd_data = rd_data_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_data    = cmd_data_q;
   assign overrun     = overrun_q;
   assign txn_count   = txn_count_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_bridge.sv
// Scoreboard bench for i2c_slave_bridge: expected frames queued at stimulus time,
// popped and compared on each cmd handshake.
module tb_i2c_slave_bridge;

   localparam int EXP_LAT = 2 + 2 + 2;

   logic        clk = 1'b0;
   logic        nreset;
   logic        i2c_start, i2c_addr_nm;
   logic [39:0] i2c_wr_data, i2c_rd_data;
   logic        cmd_valid, cmd_ready;
   logic [39:0] cmd_data;
   logic        rsp_load;
   logic [39:0] rsp_data;
   logic        overrun, overrun_clr;
   logic [7:0]  txn_count;
   logic        busy;

   int          n_checks = 0;
   int          n_errs   = 0;
   logic [39:0] exp_q[$];
   logic [7:0]  exp_cnt;
   int          lat;

   i2c_slave_bridge #(.SYNC_STAGES(2), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .nreset(nreset), .i2c_start(i2c_start), .i2c_addr_nm(i2c_addr_nm),
      .i2c_wr_data(i2c_wr_data), .i2c_rd_data(i2c_rd_data), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_data(cmd_data), .rsp_load(rsp_load), .rsp_data(rsp_data),
      .overrun(overrun), .overrun_clr(overrun_clr), .txn_count(txn_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [39:0] act, input logic [39:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (nreset && cmd_valid && cmd_ready) begin
         if (exp_q.size() == 0) check_val("unexpected_frame", cmd_data, 40'h0);
         else check_val("frame", cmd_data, exp_q.pop_front());
      end
   end

   task automatic start_txn(input logic [39:0] d, input logic nm);
      @(posedge clk); #3;
      i2c_start = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      i2c_wr_data = d;
      i2c_addr_nm = nm;
      repeat (3) @(posedge clk);
   endtask

   task automatic end_txn(output int l);
      #3;
      i2c_start = 1'b0;
      l = 0;
      for (int n = 1; n <= 16; n++) begin
         @(posedge clk); #1;
         if (cmd_valid && l == 0) l = n;
      end
      i2c_addr_nm = 1'b1;
   endtask

   task automatic run_txn(input logic [39:0] d, input logic nm, output int l);
      start_txn(d, nm);
      end_txn(l);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nreset = 1'b0; i2c_start = 1'b0; i2c_addr_nm = 1'b1; i2c_wr_data = '0;
      cmd_ready = 1'b1; rsp_load = 1'b0; rsp_data = '0; overrun_clr = 1'b0;
      exp_cnt = 8'd0;
      #12;
      check_val("rst_valid", 40'(cmd_valid), 40'h0);
      check_val("rst_data", cmd_data, 40'h0);
      check_val("rst_rd", i2c_rd_data, 40'h0);
      check_val("rst_ovr", 40'(overrun), 40'h0);
      check_val("rst_cnt", 40'(txn_count), 40'h0);
      check_val("rst_busy", 40'(busy), 40'h1);
      @(posedge clk); #3 nreset = 1'b1;
      repeat (4) @(posedge clk);
      #1 check_val("idle_busy", 40'(busy), 40'h0);

      // 1: matching write, ready high
      exp_q.push_back(40'h5544332211);
      run_txn(40'h5544332211, 1'b0, lat);
      exp_cnt++;
      check_val("t1_latency", 40'(lat), 40'(EXP_LAT));
      check_val("t1_cnt", 40'(txn_count), 40'(exp_cnt));
      check_val("t1_drained", 40'(exp_q.size()), 40'h0);

      // 2: non-matching address
      run_txn(40'h5544332211, 1'b1, lat);
      check_val("t2_valid", 40'(cmd_valid), 40'h0);
      check_val("t2_cnt", 40'(txn_count), 40'(exp_cnt));

      // 3: two writes with consumer stalled
      cmd_ready = 1'b0;
      exp_q.push_back(40'hAAAAAAAAAA);
      run_txn(40'hAAAAAAAAAA, 1'b0, lat);
      exp_cnt++;
      run_txn(40'hBBBBBBBBBB, 1'b0, lat);
      check_val("t3_valid", 40'(cmd_valid), 40'h1);
      check_val("t3_data", cmd_data, 40'hAAAAAAAAAA);
      check_val("t3_ovr", 40'(overrun), 40'h1);
      check_val("t3_cnt", 40'(txn_count), 40'(exp_cnt));
      @(posedge clk); #3 overrun_clr = 1'b1;
      @(posedge clk); #3 overrun_clr = 1'b0;
      check_val("t3b_ovr", 40'(overrun), 40'h0);
      cmd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_val("t3_drained", 40'(exp_q.size()), 40'h0);
      check_val("t3_valid_clr", 40'(cmd_valid), 40'h0);

      // 4: read-back held while bus active, last load wins
      start_txn(40'h0, 1'b1);
      #3 rsp_data = 40'hDEADBEEF00; rsp_load = 1'b1;
      @(posedge clk); #3 rsp_data = 40'h0102030405;
      @(posedge clk); #3 rsp_load = 1'b0;
      repeat (6) @(posedge clk);
      #1 check_val("t4_hold", i2c_rd_data, 40'h0);
      #2 i2c_start = 1'b0;
      begin
         int n;
         n = 0;
         do begin
            @(posedge clk); #1; n++;
         end while (busy && n < 30);
         check_val("t4_idle_seen", 40'(busy), 40'h0);
         check_val("t4_hold_capture", i2c_rd_data, 40'h0);
         @(posedge clk); #1;
         check_val("t4b_rd", i2c_rd_data, 40'h0102030405);
      end

      // 5: start drops for one clk only, then final fall
      exp_q.push_back(40'h00C0FFEE55);
      start_txn(40'h00C0FFEE55, 1'b0);
      #3 i2c_start = 1'b0;
      @(posedge clk); #3 i2c_start = 1'b1;
      repeat (10) @(posedge clk);
      #1 check_val("t5_no_glitch_cap", 40'(txn_count), 40'(exp_cnt));
      end_txn(lat);
      exp_cnt++;
      check_val("t5_cnt", 40'(txn_count), 40'(exp_cnt));
      check_val("t5_drained", 40'(exp_q.size()), 40'h0);

      // 5b: 256 captures wrap the counter back to the same value
      for (int i = 0; i < 256; i++) begin
         logic [39:0] d;
         d = {$urandom(), 8'(i)};
         exp_q.push_back(d);
         run_txn(d, 1'b0, lat);
         exp_cnt++;
      end
      check_val("t5b_wrap", 40'(txn_count), 40'(exp_cnt));
      check_val("t5b_drained", 40'(exp_q.size()), 40'h0);

      // 6: reset mid-transaction, release while start still high
      @(posedge clk); #3;
      i2c_start = 1'b1; i2c_wr_data = 40'h6666666666; i2c_addr_nm = 1'b0;
      repeat (5) @(posedge clk);
      #2 nreset = 1'b0;
      #1;
      exp_cnt = 8'd0;
      check_val("t6_rst_cnt", 40'(txn_count), 40'h0);
      check_val("t6_rst_busy", 40'(busy), 40'h1);
      check_val("t6_rst_rd", i2c_rd_data, 40'h0);
      check_val("t6_rst_valid", 40'(cmd_valid), 40'h0);
      repeat (2) @(posedge clk);
      #3 nreset = 1'b1;
      repeat (6) @(posedge clk);
      end_txn(lat);
      check_val("t6_no_frame", 40'(txn_count), 40'h0);
      check_val("t6_valid", 40'(cmd_valid), 40'h0);

      // 6b: next transaction captured normally
      exp_q.push_back(40'h0000000077);
      run_txn(40'h0000000077, 1'b0, lat);
      exp_cnt++;
      check_val("t6b_cnt", 40'(txn_count), 40'(exp_cnt));
      check_val("t6b_drained", 40'(exp_q.size()), 40'h0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
